// File: rtl/alp_pkg.sv
// Shared definitions for the alp two-register arithmetic/logic processor:
// op-code enumeration and default datapath width.
package alp_pkg;

  localparam int ALP_W_DEF = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alp_op_e;

endpackage

// File: rtl/alp_if.sv
// Strobe/operand bus into alp and the registered R0/R1/error readback.
// master drives strobes and operands; slave (the processor) drives the registers.
interface alp_if #(
  parameter int W = alp_pkg::ALP_W_DEF
);
  logic [W-1:0] data_in;
  logic [2:0]   op;
  logic         load;
  logic         comp;
  logic         clr;
  logic         ERRreg;
  logic [W-1:0] OUT_0;
  logic [W-1:0] OUT_1;

  modport master (
    output data_in, op, load, comp, clr,
    input  ERRreg, OUT_0, OUT_1
  );

  modport slave (
    input  data_in, op, load, comp, clr,
    output ERRreg, OUT_0, OUT_1
  );
endinterface

// File: rtl/alp_alu.sv
// Combinational ALU for alp: result = op(a, b) truncated to W bits, plus error flag.
// Optional ALP_SAT_EN makes ADD/SHL overflow clamp to all ones and SUB underflow to zero.
module alp_alu
  import alp_pkg::*;
#(
  parameter int W = ALP_W_DEF
) (
  input  alp_op_e      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         err
);

  logic [W:0] sum;
  logic       borrow;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign borrow = (a < b);

  always_comb begin
    result = '0;
    err    = 1'b0;
    unique case (op)
      OP_ADD: begin
        err = sum[W];
`ifdef ALP_SAT_EN
        result = sum[W] ? '1 : sum[W-1:0];
`else
        result = sum[W-1:0];
`endif
      end
      OP_SUB: begin
        err = borrow;
`ifdef ALP_SAT_EN
        result = borrow ? '0 : (a - b);
`else
        result = a - b;
`endif
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        err = a[W-1];
`ifdef ALP_SAT_EN
        result = a[W-1] ? '1 : {a[W-2:0], 1'b0};
`else
        result = {a[W-2:0], 1'b0};
`endif
      end
      OP_SHR: result = {1'b0, a[W-1:1]};
      default: begin
        result = '0;
        err    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alp.sv
// alp top: R0/R1 register pair, sticky error flag and strobe priority
// (reset > clr > load&comp > load > comp > hold). Saturation build: ALP_SAT_EN.
module alp
  import alp_pkg::*;
#(
  parameter int W = ALP_W_DEF
) (
  input logic   clk,
  input logic   reset_n,
  alp_if.slave  bus
);

  logic [W-1:0] r0;
  logic [W-1:0] r1;
  logic         err_q;
  logic [W-1:0] alu_result;
  logic         alu_err;

  alp_alu #(.W(W)) u_alu (
    .op     (alp_op_e'(bus.op)),
    .a      (r0),
    .b      (r1),
    .result (alu_result),
    .err    (alu_err)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r0    <= '0;
      r1    <= '0;
      err_q <= 1'b0;
    end else if (bus.clr) begin
      r0    <= '0;
      r1    <= '0;
      err_q <= 1'b0;
    end else if (bus.load && bus.comp) begin
      err_q <= 1'b1;
    end else if (bus.load) begin
      r1 <= r0;
      r0 <= bus.data_in;
    end else if (bus.comp) begin
      r0 <= alu_result;
      // sticky: a clean compute never clears a previous error
      if (alu_err) err_q <= 1'b1;
    end
  end

  assign bus.OUT_0  = r0;
  assign bus.OUT_1  = r1;
  assign bus.ERRreg = err_q;

endmodule

// File: tb/tb_alp.sv
// Self-checking bench for alp: directed plan sequence plus random strobes,
// compared against an integer-arithmetic reference model.
module tb_alp;

  localparam int W = 4;
  localparam int M = 1 << W;
`ifdef ALP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alp_if #(.W(W)) bus ();

  alp #(.W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int m0 = 0, m1 = 0, me = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input bit rst_n, input bit c, input bit l,
                                     input bit p, input int o, input int d);
    int t;
    if (!rst_n || c) begin
      m0 = 0; m1 = 0; me = 0;
    end else if (l && p) begin
      me = 1;
    end else if (l) begin
      m1 = m0; m0 = d;
    end else if (p) begin
      case (o)
        0: begin
          t = m0 + m1;
          if (t >= M) begin me = 1; t = SAT ? M - 1 : t - M; end
        end
        1: begin
          if (m0 < m1) begin me = 1; t = SAT ? 0 : m0 - m1 + M; end
          else t = m0 - m1;
        end
        2: t = m0 & m1;
        3: t = m0 | m1;
        4: t = m0 ^ m1;
        5: t = M - 1 - m0;
        6: begin
          t = m0 * 2;
          if (t >= M) begin me = 1; t = SAT ? M - 1 : t - M; end
        end
        default: t = m0 / 2;
      endcase
      m0 = t;
    end
  endfunction

  task automatic step(input string tag, input bit rst_n, input bit c, input bit l,
                      input bit p, input int o, input int d);
    reset_n     = rst_n;
    bus.clr     = c;
    bus.load    = l;
    bus.comp    = p;
    bus.op      = 3'(o);
    bus.data_in = W'(d);
    @(posedge clk);
    #1;
    model_step(rst_n, c, l, p, o, d);
    chk({tag, ".out0"}, int'(bus.OUT_0), m0);
    chk({tag, ".out1"}, int'(bus.OUT_1), m1);
    chk({tag, ".err"},  int'(bus.ERRreg), me);
  endtask

  task automatic ld(input string tag, input int d);
    step(tag, 1, 0, 1, 0, 0, d);
  endtask

  task automatic cp(input string tag, input int o);
    step(tag, 1, 0, 0, 1, o, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.clr = 1'b0; bus.load = 1'b0; bus.comp = 1'b0;
    bus.op = 3'd0; bus.data_in = '0;
    #2;

    step("rst0", 0, 0, 0, 0, 0, 0);
    step("rst1", 0, 0, 0, 0, 0, 0);
    step("idle", 1, 0, 0, 0, 0, 0);
    chk("reset_out0", int'(bus.OUT_0), 0);

    ld("ld3", 3);
    ld("ld5", 5);
    chk("shift_out0", int'(bus.OUT_0), 5);
    chk("shift_out1", int'(bus.OUT_1), 3);

    cp("add", 0);
    chk("add_val", int'(bus.OUT_0), 8);
    ld("ld9", 9);
    cp("add_ovf", 0);
    chk("add_ovf_val", int'(bus.OUT_0), SAT ? 15 : 1);
    chk("add_ovf_err", int'(bus.ERRreg), 1);

    step("clr", 1, 1, 0, 0, 0, 0);

    ld("ldA", 10); ld("ldC", 12); cp("and", 2);
    chk("and_val", int'(bus.OUT_0), 8);
    ld("ldA", 10); ld("ldC", 12); cp("or", 3);
    chk("or_val", int'(bus.OUT_0), 14);
    ld("ldA", 10); ld("ldC", 12); cp("xor", 4);
    chk("xor_val", int'(bus.OUT_0), 6);
    ld("ldA", 10); ld("ldC", 12); cp("not", 5);
    chk("not_val", int'(bus.OUT_0), 3);
    chk("logic_err", int'(bus.ERRreg), 0);

    ld("ld7", 7); ld("ld2", 2); cp("sub", 1);
    chk("sub_val", int'(bus.OUT_0), SAT ? 0 : 11);
    chk("sub_err", int'(bus.ERRreg), 1);

    step("clr2", 1, 1, 0, 0, 0, 0);
    ld("ld9", 9); cp("shl", 6);
    chk("shl_val", int'(bus.OUT_0), SAT ? 15 : 2);
    chk("shl_err", int'(bus.ERRreg), 1);
    ld("ld9", 9); cp("shr", 7);
    chk("shr_val", int'(bus.OUT_0), 4);
    chk("shr_err", int'(bus.ERRreg), 1);

    step("clr3", 1, 1, 0, 0, 0, 0);
    ld("ld5", 5);
    step("illegal", 1, 0, 1, 1, 0, 9);
    chk("illegal_out0", int'(bus.OUT_0), 5);
    chk("illegal_err", int'(bus.ERRreg), 1);
    step("clr_ld", 1, 1, 1, 0, 0, 7);
    chk("clr_ld_out0", int'(bus.OUT_0), 0);
    ld("ld3", 3);
    step("rst_ld", 0, 0, 1, 0, 0, 6);
    chk("rst_ld_out0", int'(bus.OUT_0), 0);

    // repeated ADD accumulates R1 into R0
    ld("ld1", 1); ld("ld2", 2);
    cp("acc0", 0); cp("acc1", 0); cp("acc2", 0);

    for (int i = 0; i < 400; i++) begin
      bit r, c, l, p;
      r = ($urandom_range(0, 29) != 0);
      c = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 1) == 0);
      step("rand", r, c, l, p, int'($urandom_range(0, 7)), int'($urandom_range(0, M - 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alp.md
Name: alp

Overview:
- Small two-register arithmetic/logic processor.
- Loads W-bit operands into a two-entry register pair (R0, R1) and computes a 3-bit-coded operation on them, writing the result back into R0.
- Keeps a sticky error flag.
- Stand-alone datapath block driven by a controller or bench supplying load/comp/clr strobes.

Parameters:
- W, 4, datapath width of data_in, R0, R1 and the ALU (W >= 2).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- data_in  input  W  operand input
- op  input  3  operation select, used only when comp=1
- load  input  1  operand load strobe
- comp  input  1  compute strobe
- clr  input  1  synchronous clear of registers and error flag
- ERRreg  output  1  sticky error flag (registered)
- OUT_0  output  W  R0 contents (registered)
- OUT_1  output  W  R1 contents (registered)

Behaviour:
- All state updates occur on the rising edge of clk. Outputs are direct register values, so each has one-cycle latency from its strobe.
- reset_n=0 at an edge: R0=0, R1=0, ERRreg=0. Reset overrides everything else.
- Priority when reset_n=1: clr > (load & comp) > load > comp > hold.
- clr=1: R0=0, R1=0, ERRreg=0. load, comp and op are ignored.
- load=1, comp=1 together: illegal. R0 and R1 hold; ERRreg<=1.
- load=1 only: R1<=R0, R0<=data_in (two-deep shift). ERRreg unchanged.
- comp=1 only: R0<=result of ALU(op, R0, R1). R1 unchanged.
- ALU op codes (a=R0, b=R1, all arithmetic modulo 2^W):
  - 000 ADD: a+b. Error if carry out.
  - 001 SUB: a-b. Error if borrow (a<b).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT: ~a.
  - 110 SHL: a<<1, LSB=0. Error if the old MSB was 1.
  - 111 SHR: a>>1 logical, MSB=0.
- On comp with error: ERRreg<=1. ERRreg is never cleared by comp; only clr or reset clears it.
- No strobe active: all registers hold.
- Result width is always truncated to W bits. Carry and borrow are not stored, only reflected in ERRreg.
- Strobes are level-sampled each edge. Holding comp high for N cycles applies the operation N times (e.g. repeated ADD accumulates R1 into R0).
- Reset asserted mid-sequence discards all state immediately at that edge.

Optional Feature:
- Macro ALP_SAT_EN.
- When defined: ADD overflow saturates R0 to all ones (2^W-1); SUB underflow saturates R0 to 0; SHL overflow saturates R0 to all ones. ERRreg is still set in each case.
- When undefined: wrap-around results as specified above.
- All other ops are identical in both builds.

Decomposition:
- Package alp_pkg holds:
  - op-code enum/localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR;
  - the default width constant.
- One combinational sub-module, alp_alu, takes (op, a, b) and returns (result[W-1:0], err).
- The top-level alp holds R0, R1, ERRreg and the priority logic.

Test Plan:
- Reset and clear: reset_n=0 for 2 cycles, then release -> OUT_0=0, OUT_1=0, ERRreg=0. Later, after loads, clr=1 -> all three return to 0 the next cycle.
- Load shift: load 3, then load 5 -> OUT_0=5, OUT_1=3.
- ADD and overflow (W=4):
  - R0=5, R1=3, comp op=000 -> OUT_0=8, ERRreg=0.
  - Then load 9 (R0=9, R1=8), op=000 -> OUT_0=1 (wrap), ERRreg=1.
  - Under ALP_SAT_EN the same sequence gives OUT_0=15.
- Logic ops: R0=0xC, R1=0xA:
  - AND -> 0x8.
  - Reload, OR -> 0xE.
  - Reload, XOR -> 0x6.
  - NOT of 0xC -> 0x3.
  - ERRreg stays 0 throughout.
- SUB/shift errors:
  - R0=2, R1=7, SUB -> OUT_0=0xB, ERRreg=1.
  - clr, then R0=0x9, SHL -> OUT_0=0x2, ERRreg=1.
  - SHR of 0x9 -> 0x4, ERRreg unchanged.
- Illegal and priority:
  - load=1 and comp=1 -> registers hold, ERRreg=1.
  - clr=1 with load=1 -> all zero.
  - reset_n=0 with clr=0 and load=1 -> all zero.
